// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
// Define UART_TX_PARITY_EN to add the parity state to the transmitter.
package uart_pkg;

   localparam int   DIV_W_DEF = 16;
   localparam logic TXD_IDLE  = 1'b1;
   localparam logic TXD_START = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter; tick marks the last cycle of a bit period.
// Reloads itself from div on every tick so bit periods chain seamlessly.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= div;
      end else if (en) begin
         cnt <= (cnt == '0) ? div : cnt - DIV_W'(1);
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter, 8N1/8N2, LSB first, one pop per frame.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int D_W   = 8,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             rdclk,
   input  logic             rd_rst,
   input  logic             tx_en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             stop2,
   input  logic             rdempty,
   input  logic [D_W-1:0]   q,
`ifdef UART_TX_PARITY_EN
   input  logic             parity_odd,
`endif
   output logic             rdreq,
   output logic             txd,
   output logic             busy,
   output logic             tx_done
);

   localparam int BC_W = $clog2(D_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(D_W - 1);

   tx_state_t        state;
   tx_state_t        state_n;
   logic [D_W-1:0]   shreg;
   logic [DIV_W-1:0] div_q;
   logic             stop2_q;
   logic [BC_W-1:0]  bit_cnt;
   logic             tick;
   logic             cnt_load;
   logic             cnt_en;
`ifdef UART_TX_PARITY_EN
   logic             par_q;
`endif

   assign cnt_load = (state == LOAD);
   assign cnt_en   = (state != IDLE) && (state != FETCH)
                  && (state != LOAD);

   uart_baud_cnt #(
      .DIV_W(DIV_W)
   ) u_baud (
      .clk (rdclk),
      .rst (rd_rst),
      .load(cnt_load),
      .en  (cnt_en),
      .div (cnt_load ? baud_div : div_q),
      .tick(tick)
   );

   always_ff @(posedge rdclk or posedge rd_rst) begin
      if (rd_rst) begin
         state   <= IDLE;
         shreg   <= '0;
         div_q   <= '0;
         stop2_q <= 1'b0;
         bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         case (state)
            LOAD: begin
               shreg   <= q;
               div_q   <= baud_div;
               stop2_q <= stop2;
               bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
               par_q   <= (^q) ^ parity_odd;
`endif
            end
            DATA: begin
               if (tick) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= (bit_cnt == LAST_BIT)
                           ? '0 : bit_cnt + BC_W'(1);
               end
            end
            // bit_cnt counts stop periods here
            STOP: begin
               if (tick) begin
                  bit_cnt <= bit_cnt + BC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      rdreq   = 1'b0;
      tx_done = 1'b0;
      txd     = TXD_IDLE;
      busy    = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (tx_en && !rdempty) begin
               state_n = FETCH;
            end
         end
         FETCH: begin
            rdreq   = 1'b1;
            state_n = LOAD;
         end
         LOAD: begin
            state_n = START;
         end
         START: begin
            txd = TXD_START;
            if (tick) begin
               state_n = DATA;
            end
         end
         DATA: begin
            txd = shreg[0];
            if (tick && bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            txd = par_q;
            if (tick) begin
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (tick && (!stop2_q || bit_cnt == BC_W'(1))) begin
               tx_done = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame-level reference, directed and random traffic.
// Build with UART_TX_PARITY_EN defined to exercise the parity bit.
module tb_fifo_uart_tx;

   localparam int D_W   = 8;
   localparam int DIV_W = 16;

   logic             rdclk = 1'b0;
   logic             rd_rst = 1'b1;
   logic             tx_en = 1'b0;
   logic [DIV_W-1:0] baud_div = 16'd3;
   logic             stop2 = 1'b0;
   logic             rdempty;
   logic [D_W-1:0]   q = '0;
   logic             rdreq;
   logic             txd;
   logic             busy;
   logic             tx_done;
`ifdef UART_TX_PARITY_EN
   logic             parity_odd = 1'b0;
`endif

   int checks = 0;
   int passes = 0;

   always #5 rdclk = ~rdclk;

   fifo_uart_tx #(
      .D_W  (D_W),
      .DIV_W(DIV_W)
   ) dut (
      .rdclk     (rdclk),
      .rd_rst    (rd_rst),
      .tx_en     (tx_en),
      .baud_div  (baud_div),
      .stop2     (stop2),
      .rdempty   (rdempty),
      .q         (q),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .rdreq     (rdreq),
      .txd       (txd),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   // FIFO model: bench writes at wp, DUT pops at rp, reference pops at mrp
   logic [7:0] mem [0:1023];
   int wp = 0;
   int rp = 0;
   int mrp = 0;

   assign rdempty = (wp == rp);

   always @(posedge rdclk) begin
      if (rdreq && wp != rp) begin
         q  <= mem[rp];
         rp <= rp + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wp] = b;
      wp++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Reference: per-cycle expected {txd,busy,rdreq,tx_done,load_marker}
   typedef struct packed {
      logic txd;
      logic busy;
      logic rdreq;
      logic done;
      logic load;
   } exp_t;

   exp_t       eq [$];
   logic [7:0] cur_b;

   function automatic exp_t mk(logic t, logic b, logic r, logic d);
      return {t, b, r, d, 1'b0};
   endfunction

   always @(negedge rdclk) begin
      exp_t e;
      int   n;
      int   ns;
      e = mk(1'b1, 1'b0, 1'b0, 1'b0);
      if (rd_rst) begin
         eq.delete();
      end else if (eq.size() == 0) begin
         if (tx_en && mrp != wp) begin
            cur_b = mem[mrp];
            mrp++;
            eq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
            eq.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
         end
      end else begin
         e = eq.pop_front();
         if (e.load) begin
            n  = int'(baud_div) + 1;
            ns = stop2 ? 2 * n : n;
            for (int i = 0; i < n; i++) eq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
            for (int k = 0; k < 8; k++)
               for (int i = 0; i < n; i++) eq.push_back(mk(cur_b[k], 1'b1, 1'b0, 1'b0));
`ifdef UART_TX_PARITY_EN
            for (int i = 0; i < n; i++)
               eq.push_back(mk((^cur_b) ^ parity_odd, 1'b1, 1'b0, 1'b0));
`endif
            for (int i = 0; i < ns; i++)
               eq.push_back(mk(1'b1, 1'b1, 1'b0, i == ns - 1));
         end
      end
      checks++;
      if ({txd, busy, rdreq, tx_done} === {e.txd, e.busy, e.rdreq, e.done}) passes++;
      else $display("FAIL model t=%0t txd/busy/rdreq/done got %b%b%b%b expected %b%b%b%b",
                    $time, txd, busy, rdreq, tx_done, e.txd, e.busy, e.rdreq, e.done);
   end

   task automatic wait_fetch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge rdclk);
         if (rdreq) ok = 1'b1;
      end
      chk("fetch_seen", int'(ok), 1);
   endtask

   // Called at the FETCH negedge; START begins two cycles later
   task automatic grab(input int n, output logic [7:0] b, output logic st,
                       output logic sp, output logic pb, output int didx);
      int off;
      b = '0; st = 1'b1; sp = 1'b0; pb = 1'b0; didx = -1; off = 0;
      while (didx < 0 && off < 3000) begin
         @(negedge rdclk);
         off++;
         if (off == 2) st = txd;
         for (int k = 0; k < 8; k++)
            if (off == 2 + (k + 1) * n) b[k] = txd;
`ifdef UART_TX_PARITY_EN
         if (off == 2 + 9 * n) pb = txd;
         if (off == 2 + 10 * n) sp = txd;
`else
         if (off == 2 + 9 * n) sp = txd;
`endif
         if (tx_done) didx = off - 2;
      end
   endtask

   task automatic step();
      @(posedge rdclk);
      #1;
   endtask

   initial begin
      bit         ok;
      logic [7:0] b;
      logic       st, sp, pb;
      int         didx, nreq, ndone, bad;
      logic       busy_at_done;

      // reset state
      @(negedge rdclk);
      chk("rst_txd", int'(txd), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rdreq", int'(rdreq), 0);
      chk("rst_done", int'(tx_done), 0);

      // A5 at baud_div=3
      step();
      rd_rst = 1'b0;
      baud_div = 16'd3;
      push(8'hA5);
      tx_en = 1'b1;
      wait_fetch(ok);
      grab(4, b, st, sp, pb, didx);
      chk("a5_start", int'(st), 0);
      chk("a5_byte", int'(b), 8'hA5);
      chk("a5_stop", int'(sp), 1);
`ifdef UART_TX_PARITY_EN
      chk("a5_done_idx", didx, 43);
`else
      chk("a5_done_idx", didx, 39);
`endif

      // three bytes back to back at baud_div=0
      step();
      baud_div = 16'd0;
      push(8'h00); push(8'hFF); push(8'h3C);
      nreq = 0; ndone = 0; busy_at_done = 1'b0;
      for (int i = 0; i < 300 && ndone < 3; i++) begin
         @(negedge rdclk);
         nreq += int'(rdreq);
         ndone += int'(tx_done);
         if (ndone == 3) busy_at_done = busy;
      end
      chk("b2b_rdreq", nreq, 3);
      chk("b2b_done", ndone, 3);
      chk("b2b_busy_last", int'(busy_at_done), 1);
      @(negedge rdclk);
      chk("b2b_busy_after", int'(busy), 0);

      // empty FIFO for 100 cycles
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge rdclk);
         if (rdreq || busy || !txd) bad++;
      end
      chk("empty_idle", bad, 0);

      // two stop bits, mid-frame config change ignored
      step();
      stop2 = 1'b1;
      baud_div = 16'd1;
      push(8'h81);
      wait_fetch(ok);
      fork
         grab(2, b, st, sp, pb, didx);
         begin
            repeat (4) @(posedge rdclk);
            #1;
            stop2 = 1'b0;
            baud_div = 16'd5;
         end
      join
      chk("s2_byte", int'(b), 8'h81);
`ifdef UART_TX_PARITY_EN
      chk("s2_done_idx", didx, 23);
`else
      chk("s2_done_idx", didx, 21);
`endif

      // reset during DATA bit 3, next byte must go out cleanly
      step();
      stop2 = 1'b0;
      baud_div = 16'd1;
      push(8'h5A); push(8'h3C);
      wait_fetch(ok);
      repeat (10) @(negedge rdclk);
      @(posedge rdclk);
      #1;
      rd_rst = 1'b1;
      #1;
      chk("rst_mid_txd", int'(txd), 1);
      chk("rst_mid_busy", int'(busy), 0);
      step();
      step();
      rd_rst = 1'b0;
      wait_fetch(ok);
      grab(2, b, st, sp, pb, didx);
      chk("post_rst_start", int'(st), 0);
      chk("post_rst_byte", int'(b), 8'h3C);

`ifdef UART_TX_PARITY_EN
      step();
      parity_odd = 1'b0;
      push(8'h07);
      wait_fetch(ok);
      grab(2, b, st, sp, pb, didx);
      chk("par_even", int'(pb), 1);
      chk("par_even_stop", int'(sp), 1);
      step();
      parity_odd = 1'b1;
      push(8'h07);
      wait_fetch(ok);
      grab(2, b, st, sp, pb, didx);
      chk("par_odd", int'(pb), 0);
      chk("par_odd_stop", int'(sp), 1);
`endif

      // random traffic against the reference
      for (int i = 0; i < 2000; i++) begin
         step();
         if ($urandom_range(15) == 0 && wp < 1000) push(8'($urandom_range(255)));
         if ($urandom_range(39) == 0) tx_en = ~tx_en;
         if ($urandom_range(31) == 0) baud_div = DIV_W'($urandom_range(3));
         if ($urandom_range(31) == 0) stop2 = 1'($urandom_range(1));
`ifdef UART_TX_PARITY_EN
         if ($urandom_range(31) == 0) parity_odd = 1'($urandom_range(1));
`endif
      end
      step();
      tx_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge rdclk);
         if (wp == rp && !busy) ok = 1'b1;
      end
      chk("drained", int'(ok), 1);
      chk("model_idle", eq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
